// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: mode encodings, per-mode active-area tables
// and the mode-sequencer state encoding. The sync generator uses the same tables.
package vga_timing_pkg;

    localparam logic [1:0] MODE_640X480  = 2'd0;
    localparam logic [1:0] MODE_768X576  = 2'd1;
    localparam logic [1:0] MODE_800X600  = 2'd2;
    localparam logic [1:0] MODE_1024X768 = 2'd3;

    // Indexed by the mode encoding above.
    localparam logic [9:0]  V_ACTIVE_LINES  [4] = '{10'd480, 10'd576, 10'd600, 10'd768};
    localparam logic [10:0] H_ACTIVE_PIXELS [4] = '{11'd640, 11'd768, 11'd800, 11'd1024};

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        SETTLE   = 2'd1,
        RUN      = 2'd2,
        WAIT_VBL = 2'd3
    } seq_state_e;

    function automatic logic in_vblank(input logic [1:0] m, input logic [9:0] v);
        return v >= V_ACTIVE_LINES[m];
    endfunction

endpackage

// File: rtl/vga_mode_sequencer.sv
// Sequences VGA mode changes: waits for vertical blank, blanks the pixel path,
// holds the sync generator in reset, then waits for the monitor to re-lock.
module vga_mode_sequencer
    import vga_timing_pkg::*;
#(
    parameter int DEFAULT_MODE  = 3,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [1:0]  req_mode,
    output logic        req_ready,
    input  logic [10:0] hpos,
    input  logic [9:0]  vpos,
    output logic [1:0]  mode,
    output logic        gen_reset,
    output logic        blank,
    output logic        done
);

    localparam logic [1:0] RESET_MODE = 2'(DEFAULT_MODE);
    localparam logic [7:0] LAST_HOLD  = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LAST_FRAME = 4'(SETTLE_FRAMES - 1);

    seq_state_e state_q, state_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] target_q, target_d;
    logic       gen_reset_q, gen_reset_d;
    logic       blank_q, blank_d;
    logic       req_ready_q, req_ready_d;
    logic       done_q, done_d;
    logic       pending_q, pending_d;

    logic frame_start;

    // The generator counters sit at 0 while held, so the first released cycle counts.
    assign frame_start = !gen_reset_q && (hpos == 11'd0) && (vpos == 10'd0);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        frame_cnt_d = frame_cnt_q;
        mode_d      = mode_q;
        target_d    = target_q;
        gen_reset_d = gen_reset_q;
        blank_d     = blank_q;
        req_ready_d = req_ready_q;
        pending_d   = pending_q;
        done_d      = 1'b0;

        unique case (state_q)
            HOLD: begin
                if (hold_cnt_q == LAST_HOLD) begin
                    gen_reset_d = 1'b0;
                    frame_cnt_d = 4'd0;
                    state_d     = SETTLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            SETTLE: begin
                if (frame_start) begin
                    if (frame_cnt_q == LAST_FRAME) begin
                        blank_d     = 1'b0;
                        req_ready_d = 1'b1;
                        done_d      = pending_q;
                        pending_d   = 1'b0;
                        state_d     = RUN;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end

            RUN: begin
                if (!req_ready_q) begin
                    // Only a same-mode request leaves RUN not ready; re-arm after its done pulse.
                    req_ready_d = 1'b1;
                end else if (req_valid) begin
                    req_ready_d = 1'b0;
                    target_d    = req_mode;
                    if (req_mode == mode_q) begin
                        done_d = 1'b1;
                    end else begin
                        blank_d   = 1'b1;
                        pending_d = 1'b1;
                        state_d   = WAIT_VBL;
                    end
                end
            end

            WAIT_VBL: begin
                // Blanking is judged against the outgoing mode's active height.
                if (in_vblank(mode_q, vpos)) begin
                    mode_d      = target_q;
                    gen_reset_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                    state_d     = HOLD;
                end
            end

            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_cnt_q  <= 8'd0;
            frame_cnt_q <= 4'd0;
            mode_q      <= RESET_MODE;
            target_q    <= RESET_MODE;
            gen_reset_q <= 1'b1;
            blank_q     <= 1'b1;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            mode_q      <= mode_d;
            target_q    <= target_d;
            gen_reset_q <= gen_reset_d;
            blank_q     <= blank_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            pending_q   <= pending_d;
        end
    end

    assign mode      = mode_q;
    assign gen_reset = gen_reset_q;
    assign blank     = blank_q;
    assign req_ready = req_ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: a small sync-generator model feeds
// hpos/vpos; a scoreboard of expected mode switches and done pulses is drained by a monitor.
module tb_vga_mode_sequencer;

    localparam int H_TOTAL     = 4;
    localparam int V_TOTAL     = 800;
    localparam int HOLD_CYCLES = 16;
    localparam int WAIT_MAX    = 8000;

    typedef enum int {EV_SWITCH = 0, EV_DONE = 1} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [1:0] mode;
        logic       ready;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [1:0]  req_mode;
    logic        req_ready;
    logic [10:0] hpos;
    logic [9:0]  vpos;
    logic [1:0]  mode;
    logic        gen_reset;
    logic        blank;
    logic        done;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vga_mode_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .hpos      (hpos),
        .vpos      (vpos),
        .mode      (mode),
        .gen_reset (gen_reset),
        .blank     (blank),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync generator model: synchronous reset from gen_reset, compact horizontal period.
    always @(posedge clk or posedge reset) begin
        if (reset || gen_reset) begin
            hpos <= 11'd0;
            vpos <= 10'd0;
        end else if (hpos == 11'(H_TOTAL - 1)) begin
            hpos <= 11'd0;
            vpos <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
        end else begin
            hpos <= hpos + 11'd1;
        end
    end

    function automatic int active_lines(input logic [1:0] m);
        case (m)
            2'd0:    return 480;
            2'd1:    return 576;
            2'd2:    return 600;
            default: return 768;
        endcase
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: pops the scoreboard on each mode switch and each done pulse.
    logic [1:0] prev_mode;
    logic [9:0] prev_vpos;
    logic       prev_gen_reset;
    bit         prev_valid = 1'b0;
    int         hold_len   = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
            hold_len   = 0;
        end else begin
            if (gen_reset) begin
                hold_len++;
            end else if (prev_valid && prev_gen_reset) begin
                check("gen_reset_cycles", hold_len, HOLD_CYCLES);
                hold_len = 0;
            end

            if (prev_valid && mode !== prev_mode) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_mode_switch");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_switch_kind", int'(EV_SWITCH), int'(e.kind));
                    check("sb_switch_mode", int'(mode), int'(e.mode));
                    check("sb_switch_gen_reset", int'(gen_reset), 1);
                    check("sb_switch_in_vblank", int'(int'(prev_vpos) >= active_lines(prev_mode)), 1);
                end
            end

            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done_kind", int'(EV_DONE), int'(e.kind));
                    check("sb_done_mode", int'(mode), int'(e.mode));
                    check("sb_done_ready", int'(req_ready), int'(e.ready));
                    check("sb_done_blank", int'(blank), 0);
                end
            end

            prev_mode      = mode;
            prev_vpos      = vpos;
            prev_gen_reset = gen_reset;
            prev_valid     = 1'b1;
        end
    end

    task automatic push_exp(input ev_kind_e kind, input logic [1:0] m, input logic rdy);
        exp_t e;
        e.kind  = kind;
        e.mode  = m;
        e.ready = rdy;
        exp_q.push_back(e);
    endtask

    // Waits for req_ready, counting frame starts seen on the way.
    task automatic wait_ready(output int frame_starts);
        frame_starts = 0;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) return;
            if (gen_reset === 1'b0 && hpos == 11'd0 && vpos == 10'd0) frame_starts++;
        end
        fail("timeout_wait_ready");
    endtask

    task automatic wait_vpos(input int target);
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (int'(vpos) == target) return;
        end
        fail("timeout_wait_vpos");
    endtask

    task automatic wait_mode(input logic [1:0] target, output int vpos_before);
        vpos_before = -1;
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (mode === target) return;
            vpos_before = int'(vpos);
        end
        fail("timeout_wait_mode");
    endtask

    task automatic wait_gen_release();
        for (int i = 0; i < WAIT_MAX; i++) begin
            @(negedge clk);
            if (gen_reset === 1'b0) return;
        end
        fail("timeout_wait_gen_release");
    endtask

    task automatic issue(input logic [1:0] m);
        req_valid = 1'b1;
        req_mode  = m;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int vb;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_mode  = 2'd0;

        // Reset values.
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_mode", int'(mode), 3);
        check("rst_gen_reset", int'(gen_reset), 1);
        check("rst_blank", int'(blank), 1);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_done", int'(done), 0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Power-up: hold, two frame starts, then ready with no done.
        wait_ready(fs);
        check("pwr_frame_starts", fs, 2);
        check("pwr_blank", int'(blank), 0);
        check("pwr_mode", int'(mode), 3);
        check("pwr_done", int'(done), 0);

        // Same-mode request.
        push_exp(EV_DONE, 2'd3, 1'b0);
        issue(2'd3);
        @(negedge clk);
        check("same_ready_n1", int'(req_ready), 0);
        check("same_blank_n1", int'(blank), 0);
        check("same_gen_reset_n1", int'(gen_reset), 0);
        check("same_done_n1", int'(done), 1);
        @(negedge clk);
        check("same_ready_n2", int'(req_ready), 1);
        check("same_done_n2", int'(done), 0);
        check("same_blank_n2", int'(blank), 0);

        // 3 -> 0 requested mid-frame.
        wait_vpos(100);
        push_exp(EV_SWITCH, 2'd0, 1'b0);
        push_exp(EV_DONE, 2'd0, 1'b1);
        issue(2'd0);
        @(negedge clk);
        check("sw30_blank_n1", int'(blank), 1);
        check("sw30_ready_n1", int'(req_ready), 0);
        check("sw30_mode_n1", int'(mode), 3);
        wait_mode(2'd0, vb);
        check("sw30_vpos_before_switch", vb, 768);
        check("sw30_gen_reset", int'(gen_reset), 1);
        wait_ready(fs);
        check("sw30_frame_starts", fs, 2);
        check("sw30_done_with_ready", int'(done), 1);

        // 0 -> 3 requested while already in vertical blank.
        wait_vpos(770);
        push_exp(EV_SWITCH, 2'd3, 1'b0);
        push_exp(EV_DONE, 2'd3, 1'b1);
        issue(2'd3);
        @(negedge clk);
        check("vbl_mode_entry", int'(mode), 0);
        check("vbl_blank_entry", int'(blank), 1);
        @(negedge clk);
        check("vbl_mode_next", int'(mode), 3);
        check("vbl_gen_reset_next", int'(gen_reset), 1);
        wait_ready(fs);
        check("vbl_frame_starts", fs, 2);

        // Held request for mode 1 during a busy 3 -> 2 switch.
        push_exp(EV_SWITCH, 2'd2, 1'b0);
        push_exp(EV_DONE, 2'd2, 1'b1);
        push_exp(EV_SWITCH, 2'd1, 1'b0);
        push_exp(EV_DONE, 2'd1, 1'b1);
        req_valid = 1'b1;
        req_mode  = 2'd2;
        @(posedge clk);
        #1 req_mode = 2'd1;
        wait_ready(fs);
        check("held_mode_at_ready", int'(mode), 2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("held_accept_ready", int'(req_ready), 0);
        check("held_accept_blank", int'(blank), 1);
        wait_ready(fs);
        check("held_final_mode", int'(mode), 1);

        // 1 -> 3, then 3 -> 1 interrupted by reset during SETTLE.
        push_exp(EV_SWITCH, 2'd3, 1'b0);
        push_exp(EV_DONE, 2'd3, 1'b1);
        issue(2'd3);
        wait_ready(fs);
        push_exp(EV_SWITCH, 2'd1, 1'b0);
        issue(2'd1);
        wait_mode(2'd1, vb);
        wait_gen_release();
        repeat (10) @(negedge clk);
        check("mid_blank_settle", int'(blank), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_mode", int'(mode), 3);
        check("mid_rst_gen_reset", int'(gen_reset), 1);
        check("mid_rst_blank", int'(blank), 1);
        check("mid_rst_ready", int'(req_ready), 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        wait_ready(fs);
        check("mid_rst_frame_starts", fs, 2);
        check("mid_rst_final_mode", int'(mode), 3);
        repeat (4) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_mode_sequencer.md
# vga_mode_sequencer

Sequences video-mode changes for the VGA timing generator. It accepts a mode-change request and waits for vertical blank. It then blanks pixel output, holds the timing generator in reset while the new mode is applied, and waits a fixed number of frames for the monitor to re-lock before unblanking. It sits between the host/register interface and the sync generator, and drives that generator's `mode` and `reset` inputs plus the pixel-path blank gate.

## Interface
Parameters:
- `DEFAULT_MODE`, 3: mode loaded at reset (0=640x480, 1=768x576, 2=800x600, 3=1024x768).
- `HOLD_CYCLES`, 16: cycles `gen_reset` is held high per switch, 1..255.
- `SETTLE_FRAMES`, 2: frame starts counted after reset release before unblank, 1..15.

Ports:
- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  mode-change request valid.
- `req_mode`  in  2  requested mode, sampled when `req_valid && req_ready`.
- `req_ready`  out  1  sequencer idle and able to accept a request.
- `hpos`  in  11  horizontal counter from the timing generator.
- `vpos`  in  10  vertical counter from the timing generator.
- `mode`  out  2  current mode, drives the generator `mode` input (registered).
- `gen_reset`  out  1  synchronous reset to the timing generator (registered).
- `blank`  out  1  forces pixel RGB to black when high (registered).
- `done`  out  1  one-cycle pulse when an accepted request completes.

## Operation
- States: HOLD, SETTLE, RUN, WAIT_VBL.
- Reset (async) values:
  - state=HOLD, hold counter=0, frame counter=0.
  - `mode`=DEFAULT_MODE, `gen_reset`=1, `blank`=1.
  - `req_ready`=0, `done`=0, pending-done flag=0.
- HOLD: `gen_reset`=1, `blank`=1. Counts HOLD_CYCLES cycles. On the edge ending the last cycle: `gen_reset`←0, frame counter←0, go to SETTLE.
- SETTLE:
  - `blank`=1. A frame start is any cycle with `gen_reset`==0 && `hpos`==0 && `vpos`==0.
  - The first cycle after release is a frame start, because the generator counters sit at 0.
  - On the SETTLE_FRAMES-th frame start: `blank`←0, `req_ready`←1, `done`←pending flag, pending←0, go to RUN.
- RUN:
  - `req_ready`=1.
  - Request accepted when `req_valid && req_ready`. At that edge `req_ready`←0 and the target is latched.
  - Target == `mode`: `done`←1 next cycle, stay in RUN, no blanking. `req_ready` returns 1 the cycle after the `done` pulse.
  - Target != `mode`: `blank`←1, pending←1, go to WAIT_VBL.
- WAIT_VBL:
  - Vertical blank is detected when `vpos` >= V_ACTIVE_LINES[`mode`], using the current (old) mode.
  - On the first such cycle: `mode`←target, `gen_reset`←1, hold counter←0, go to HOLD.
  - If already in vertical blank at entry, the transition occurs on the first WAIT_VBL cycle.
- `req_mode`/`req_valid` are ignored whenever `req_ready`=0. A held `req_valid` is accepted on the first ready cycle.
- The power-up sequence (HOLD→SETTLE→RUN) produces no `done` pulse.
- Reset asserted mid-sequence: immediate return to reset values, and `mode` reverts to DEFAULT_MODE. The pending request is dropped without `done`.
- Counter widths: hold 8 bits, frame 4 bits, no wrap within legal parameter ranges.

## Timing
- Request edge N (different mode): `blank`=1 and `req_ready`=0 from N+1.
- Vblank detected at cycle M: `mode` and `gen_reset` change together at M+1.
- `gen_reset` is high for exactly HOLD_CYCLES cycles.
- Same-mode request at edge N: `done`=1 in cycle N+1 only, `req_ready`=1 again at N+2.
- Different-mode request: `blank` falls, `done` pulses and `req_ready` rises all on the same edge.
- `mode` never changes while `vpos` < V_ACTIVE_LINES of the outgoing mode.
- `mode`, `gen_reset` and `blank` are glitch-free register outputs.

## Structure
- Shared package `vga_timing_pkg`:
  - mode encoding constants.
  - per-mode V_ACTIVE_LINES / H_ACTIVE_PIXELS tables.
  - state enum.
  - The timing generator uses the same tables, so there is a single source of truth.
- No sub-module needed. One FSM with two counters, about 150–250 lines.

## Test plan
- Power-up: reset high 5 cycles, then low → `gen_reset` high 16 cycles. `blank` drops at the 2nd frame start. `req_ready`=1, no `done`, `mode`=3.
- Switch 3→0 requested at vpos=100 → `blank`=1 next cycle. `mode`=0 and `gen_reset`=1 exactly one cycle after vpos first reads 768. `gen_reset` high 16 cycles. `done` one cycle after the 2nd frame start.
- Request mode 3 while `mode`=3 → `done` at N+1, `blank` stays 0, `gen_reset` stays 0, `req_ready` back at N+2.
- Request issued while vpos=770 (already in vblank) → `mode` changes on the cycle after entry to WAIT_VBL.
- `req_valid` held with mode 1 during a busy switch to 2 → ignored until `req_ready`. Then accepted, and the sequence 2→1 runs.
- `reset` asserted during SETTLE after 3→1 → outputs asynchronously return to `mode`=3, `gen_reset`=1, `blank`=1. No `done` is produced.
